// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for decode_stage.
// The slave modport is the decode stage; master is the surrounding pipeline.
interface decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic [3:0]  out_alu_func;
  logic [1:0]  out_sel_a;
  logic        out_sel_b;
  logic        out_cmp_signed;
  logic        out_is_branch;
  logic        out_is_jump;
  logic        out_mem_load;
  logic        out_mem_store;
  logic [2:0]  out_funct3;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
           out_alu_func, out_sel_a, out_sel_b, out_cmp_signed, out_is_branch,
           out_is_jump, out_mem_load, out_mem_store, out_funct3, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
           out_alu_func, out_sel_a, out_sel_b, out_cmp_signed, out_is_branch,
           out_is_jump, out_mem_load, out_mem_store, out_funct3, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into a one-deep registered bundle
// behind a valid/ready skid-free handshake, feeding the ALU operand selects.
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic           clk,
  input  logic           reset_n,
  decode_stage_if.slave  bus
);

  typedef enum logic [3:0] {
    F_SLL = 4'd0, F_SRL = 4'd1, F_SRA = 4'd2, F_ADD = 4'd3,
    F_SUB = 4'd4, F_OR  = 4'd5, F_AND = 4'd6, F_XOR = 4'd7,
    F_EQ  = 4'd8, F_NE  = 4'd9, F_GT  = 4'd10, F_GE = 4'd11,
    F_LT  = 4'd12, F_LE = 4'd13
  } func_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    func_e       func;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        cmp_signed;
    logic        is_branch;
    logic        is_jump;
    logic        mem_load;
    logic        mem_store;
    logic [2:0]  funct3;
    logic        illegal;
  } bundle_t;

  localparam logic [1:0] SA_RS1 = 2'd0, SA_PC = 2'd1, SA_ZERO = 2'd2;

  logic [31:0] w_i;
  logic [6:0]  w_op;
  logic [6:0]  w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt;
  logic        w_ill;
  logic        w_in_ready;
  bundle_t     w_dec;
  bundle_t     r_b;
  logic        r_valid;

  assign w_i     = bus.in_instr;
  assign w_op    = w_i[6:0];
  assign w_f3    = w_i[14:12];
  assign w_f7    = w_i[31:25];
  assign w_imm_i = {{20{w_i[31]}}, w_i[31:20]};
  assign w_imm_s = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
  assign w_imm_b = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
  assign w_imm_u = {w_i[31:12], 12'h000};
  assign w_imm_j = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
  assign w_shamt = {27'd0, w_i[24:20]};

  always_comb begin
    w_ill        = 1'b0;
    w_dec        = '0;
    w_dec.pc     = bus.in_pc;
    w_dec.rs1    = w_i[19:15];
    w_dec.rs2    = w_i[24:20];
    w_dec.rd     = w_i[11:7];
    w_dec.imm    = w_imm_i;
    w_dec.func   = F_ADD;
    w_dec.funct3 = w_f3;
    case (w_op)
      7'b0110111: begin w_dec.sel_a = SA_ZERO; w_dec.sel_b = 1'b1; w_dec.imm = w_imm_u; end
      7'b0010111: begin w_dec.sel_a = SA_PC;   w_dec.sel_b = 1'b1; w_dec.imm = w_imm_u; end
      7'b1101111: begin
        w_dec.sel_a = SA_PC; w_dec.sel_b = 1'b1; w_dec.imm = w_imm_j; w_dec.is_jump = 1'b1;
      end
      7'b1100111: begin
        w_ill         = (w_f3 != 3'b000);
        w_dec.sel_b   = 1'b1;
        w_dec.is_jump = 1'b1;
      end
      7'b1100011: begin
        w_dec.rd        = 5'd0;
        w_dec.imm       = w_imm_b;
        w_dec.is_branch = 1'b1;
        case (w_f3)
          3'b000: w_dec.func = F_EQ;
          3'b001: w_dec.func = F_NE;
          3'b100: begin w_dec.func = F_LT; w_dec.cmp_signed = 1'b1; end
          3'b101: begin w_dec.func = F_GE; w_dec.cmp_signed = 1'b1; end
          3'b110: w_dec.func = F_LT;
          3'b111: w_dec.func = F_GE;
          default: w_ill = 1'b1;
        endcase
      end
      7'b0000011: begin
        w_ill          = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
        w_dec.sel_b    = 1'b1;
        w_dec.mem_load = 1'b1;
      end
      7'b0100011: begin
        w_ill           = w_f3[2] || (w_f3 == 3'b011);
        w_dec.sel_b     = 1'b1;
        w_dec.imm       = w_imm_s;
        w_dec.rd        = 5'd0;
        w_dec.mem_store = 1'b1;
      end
      7'b0010011: begin
        w_dec.sel_b = 1'b1;
        case (w_f3)
          3'b000: w_dec.func = F_ADD;
          3'b010: begin w_dec.func = F_LT; w_dec.cmp_signed = 1'b1; end
          3'b011: w_dec.func = F_LT;
          3'b100: w_dec.func = F_XOR;
          3'b110: w_dec.func = F_OR;
          3'b111: w_dec.func = F_AND;
          3'b001: begin
            w_dec.func = F_SLL;
            w_dec.imm  = w_shamt;
            w_ill      = (w_f7 != 7'b0000000);
          end
          default: begin
            w_dec.imm = w_shamt;
            if (w_f7 == 7'b0000000)      w_dec.func = F_SRL;
            else if (w_f7 == 7'b0100000) w_dec.func = F_SRA;
            else                         w_ill      = 1'b1;
          end
        endcase
      end
      7'b0110011: begin
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'b000: w_dec.func = F_ADD;
            3'b001: w_dec.func = F_SLL;
            3'b010: begin w_dec.func = F_LT; w_dec.cmp_signed = 1'b1; end
            3'b011: w_dec.func = F_LT;
            3'b100: w_dec.func = F_XOR;
            3'b101: w_dec.func = F_SRL;
            3'b110: w_dec.func = F_OR;
            default: w_dec.func = F_AND;
          endcase
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
          w_dec.func = F_SUB;
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
          w_dec.func = F_SRA;
        end else begin
          w_ill = 1'b1;
        end
      end
      7'b0001111: w_dec.rd = 5'd0;
      default:    w_ill = 1'b1;
    endcase
    // Illegal encodings still flow downstream as an inert ADD carrying the trap flag.
    if (w_ill) begin
      w_dec.rd         = 5'd0;
      w_dec.func       = F_ADD;
      w_dec.sel_a      = SA_RS1;
      w_dec.sel_b      = 1'b0;
      w_dec.cmp_signed = 1'b0;
      w_dec.is_branch  = 1'b0;
      w_dec.is_jump    = 1'b0;
      w_dec.mem_load   = 1'b0;
      w_dec.mem_store  = 1'b0;
    end
    w_dec.illegal = w_ill;
  end

  assign w_in_ready   = !r_valid || bus.out_ready;
  assign bus.in_ready = w_in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_b       <= '0;
      r_b.pc    <= RESET_PC;
      r_b.func  <= F_ADD;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_in_ready) begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) r_b <= w_dec;
    end
  end

  assign bus.out_valid      = r_valid;
  assign bus.out_pc         = r_b.pc;
  assign bus.out_rs1        = r_b.rs1;
  assign bus.out_rs2        = r_b.rs2;
  assign bus.out_rd         = r_b.rd;
  assign bus.out_imm        = r_b.imm;
  assign bus.out_alu_func   = r_b.func;
  assign bus.out_sel_a      = r_b.sel_a;
  assign bus.out_sel_b      = r_b.sel_b;
  assign bus.out_cmp_signed = r_b.cmp_signed;
  assign bus.out_is_branch  = r_b.is_branch;
  assign bus.out_is_jump    = r_b.is_jump;
  assign bus.out_mem_load   = r_b.mem_load;
  assign bus.out_mem_store  = r_b.mem_store;
  assign bus.out_funct3     = r_b.funct3;
  assign bus.out_illegal    = r_b.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed RV32I vectors, stall, flush and
// mid-stall reset, with a handshake model deciding which bundles must appear.
module tb_decode_stage;
  localparam logic [31:0] RPC = 32'h0000_0100;

  typedef struct {
    logic [31:0] pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  fn;
    logic [1:0]  sa;
    logic        sb, cs, br, jp, ld, st, ill;
    logic [2:0]  f3;
    logic        crs, cimm;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if bus();
  decode_stage #(.RESET_PC(RPC)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int   checks = 0, errors = 0, popped = 0;
  exp_t q[$];
  exp_t cur_exp;
  logic m_valid = 1'b0;

  function automatic exp_t mk(input logic [31:0] pc, imm, input logic [4:0] rs1, rs2, rd,
                              input logic [3:0] fn, input logic [1:0] sa,
                              input logic sb, cs, br, jp, ld, st, ill,
                              input logic [2:0] f3, input logic crs, cimm);
    exp_t e;
    e.pc = pc; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.fn = fn; e.sa = sa;
    e.sb = sb; e.cs = cs; e.br = br; e.jp = jp; e.ld = ld; e.st = st; e.ill = ill;
    e.f3 = f3; e.crs = crs; e.cimm = cimm;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, req);
    end
  endtask

  task automatic cmp_bundle(input exp_t e);
    string t;
    t = $sformatf("pc%0h", e.pc);
    check({t, ".pc"},      bus.out_pc, e.pc);
    check({t, ".rd"},      bus.out_rd, e.rd);
    check({t, ".func"},    bus.out_alu_func, e.fn);
    check({t, ".illegal"}, bus.out_illegal, e.ill);
    check({t, ".cmp_s"},   bus.out_cmp_signed, e.cs);
    check({t, ".branch"},  bus.out_is_branch, e.br);
    check({t, ".jump"},    bus.out_is_jump, e.jp);
    check({t, ".load"},    bus.out_mem_load, e.ld);
    check({t, ".store"},   bus.out_mem_store, e.st);
    check({t, ".funct3"},  bus.out_funct3, e.f3);
    if (!e.ill) begin
      check({t, ".sel_a"}, bus.out_sel_a, e.sa);
      check({t, ".sel_b"}, bus.out_sel_b, e.sb);
    end
    if (e.crs) begin
      check({t, ".rs1"}, bus.out_rs1, e.rs1);
      check({t, ".rs2"}, bus.out_rs2, e.rs2);
    end
    if (e.cimm) check({t, ".imm"}, bus.out_imm, e.imm);
  endtask

  // Handshake model: owns the expected queue and the expected out_valid.
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_valid = 1'b0;
      q.delete();
    end else if (bus.flush) begin
      if (m_valid && !bus.out_ready && q.size() > 0) void'(q.pop_back());
      m_valid = 1'b0;
    end else if (!m_valid || bus.out_ready) begin
      if (bus.in_valid) q.push_back(cur_exp);
      m_valid = bus.in_valid;
    end
  end

  // Monitor: a bundle presented with out_ready high is consumed at the next edge.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      check("out_valid", bus.out_valid, m_valid);
      check("in_ready", bus.in_ready, !m_valid || bus.out_ready);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_bundle got pc %h want none", bus.out_pc);
        end else begin
          popped++;
          cmp_bundle(q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [31:0] ins, input exp_t e);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    bus.in_pc    = e.pc;
    cur_exp      = e;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] h_pc, h_imm;
    logic [3:0]  h_fn;
    logic [4:0]  h_rd;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    cur_exp = mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst.out_valid", bus.out_valid, 1'b0);
    check("rst.out_pc", bus.out_pc, RPC);
    check("rst.func", bus.out_alu_func, 4'd3);
    check("rst.rd", bus.out_rd, 5'd0);
    check("rst.imm", bus.out_imm, 32'd0);
    check("rst.illegal", bus.out_illegal, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;
    #1 check("rst.in_ready", bus.in_ready, 1'b1);

    // LUI and JAL, then stall JAL and reset in the middle of the stall.
    send(32'h12345137, mk(32'h200, 32'h12345000, 0, 0, 2, 3, 2, 1, 0, 0, 0, 0, 0, 0, 5, 0, 1));
    send(32'h010000EF, mk(32'h204, 32'd16, 0, 0, 1, 3, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    bus.out_ready = 1'b0;
    send(32'h0020A223, mk(32'h2F0, 32'd4, 1, 2, 0, 3, 0, 1, 0, 0, 0, 0, 1, 0, 2, 1, 1));
    #3 reset_n = 1'b0;
    #1;
    check("midrst.out_valid", bus.out_valid, 1'b0);
    check("midrst.out_pc", bus.out_pc, RPC);
    check("midrst.func", bus.out_alu_func, 4'd3);
    bus.in_valid = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1; bus.out_ready = 1'b1;

    // Back-to-back directed vectors.
    send(32'h00500093, mk(32'h300, 32'd5, 0, 5, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    send(32'h402081B3, mk(32'h304, 32'd0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    send(32'h0020C463, mk(32'h308, 32'd8, 1, 2, 0, 12, 0, 0, 1, 1, 0, 0, 0, 0, 4, 1, 1));
    send(32'h40335293, mk(32'h30C, 32'd3, 6, 3, 5, 2, 0, 1, 0, 0, 0, 0, 0, 0, 5, 1, 1));
    send(32'hFFFFFFFF, mk(32'h310, 32'd0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0));
    send(32'h0020A223, mk(32'h314, 32'd4, 1, 2, 0, 3, 0, 1, 0, 0, 0, 0, 1, 0, 2, 1, 1));
    send(32'hFFC12283, mk(32'h318, 32'hFFFFFFFC, 2, 28, 5, 3, 0, 1, 0, 0, 0, 1, 0, 0, 2, 1, 1));
    send(32'h0020A063, mk(32'h31C, 32'd0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
    send(32'h0020B233, mk(32'h320, 32'd0, 1, 2, 4, 12, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0));
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // Hold: capture XOR, keep offering OR with out_ready low, then flush both.
    bus.out_ready = 1'b0;
    send(32'h0020C333, mk(32'h400, 32'd0, 1, 2, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0));
    h_pc = bus.out_pc; h_imm = bus.out_imm; h_fn = bus.out_alu_func; h_rd = bus.out_rd;
    check("hold.captured_pc", h_pc, 32'h400);
    bus.in_instr = 32'h0020E2B3; bus.in_pc = 32'h404;
    cur_exp = mk(32'h404, 32'd0, 1, 2, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold.pc", bus.out_pc, h_pc);
      check("hold.func", bus.out_alu_func, h_fn);
      check("hold.rd", bus.out_rd, h_rd);
      check("hold.imm", bus.out_imm, h_imm);
      check("hold.in_ready", bus.in_ready, 1'b0);
      check("hold.out_valid", bus.out_valid, 1'b1);
    end
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    check("flush.out_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b1;
    send(32'h0020F3B3, mk(32'h408, 32'd0, 1, 2, 7, 6, 0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0));
    bus.in_valid = 1'b0;

    for (int i = 0; i < 20 && (q.size() != 0 || m_valid); i++) @(posedge clk);
    @(negedge clk);
    check("drain.queue", q.size(), 0);
    check("drain.delivered", popped, 11);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
